// File: rtl/pixel_stream_pipe.sv
// rtl/pixel_stream_pipe.sv - elastic pixel pipeline with frame markers, counters and optional frame checksum
// Optional checksum build: define PIXPIPE_CHECKSUM_EN.
module pixel_stream_pipe #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int DEPTH  = 2,
    localparam int COL_W = $clog2(IMG_W),
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [15:0]       frame_cnt,
    output logic              chk_done,
    output logic              chk_match,
    output logic [15:0]       in_sum,
    output logic [15:0]       out_sum
);
    logic [DEPTH-1:0]  stg_valid;
    logic [DATA_W-1:0] stg_data [DEPTH];
    logic [DEPTH-1:0]  stg_take;

    // A stage may load when it is empty or when every stage downstream of it is draining.
    always_comb begin
        logic acc;
        acc      = m_ready;
        stg_take = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            acc         = ~stg_valid[k] | acc;
            stg_take[k] = acc;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic              up_valid;
        logic [DATA_W-1:0] up_data;
        logic              v;
        logic [DATA_W-1:0] d;

        if (g == 0) begin : g_head
            assign up_valid = s_valid;
            assign up_data  = s_data;
        end else begin : g_body
            assign up_valid = stg_valid[g-1];
            assign up_data  = stg_data[g-1];
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v <= 1'b0;
                d <= '0;
            end else if (stg_take[g]) begin
                v <= up_valid;
                if (up_valid) begin
                    d <= up_data;
                end
            end
        end

        assign stg_valid[g] = v;
        assign stg_data[g]  = d;
    end

    assign s_ready = rst & stg_take[0];
    assign m_valid = stg_valid[DEPTH-1];
    assign m_data  = stg_data[DEPTH-1];

    logic out_beat;
    logic col_last;
    logic row_last;
    logic eof_beat;

    assign out_beat = m_valid & m_ready;
    assign col_last = (col == COL_W'(IMG_W - 1));
    assign row_last = (row == ROW_W'(IMG_H - 1));
    assign eof_beat = out_beat & col_last & row_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col       <= '0;
            row       <= '0;
            frame_cnt <= '0;
        end else if (out_beat) begin
            if (col_last) begin
                col <= '0;
                if (row_last) begin
                    row       <= '0;
                    frame_cnt <= frame_cnt + 16'd1;
                end else begin
                    row <= row + ROW_W'(1);
                end
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    assign m_sof = m_valid & (col == '0) & (row == '0);
    assign m_eol = m_valid & col_last;
    assign m_eof = m_valid & col_last & row_last;

`ifdef PIXPIPE_CHECKSUM_EN
    localparam int PIX_N = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(PIX_N);

    logic [CNT_W-1:0] in_cnt;
    logic [15:0]      in_run;
    logic [15:0]      in_pend;
    logic [15:0]      out_run;
    logic [15:0]      s_pix;
    logic [15:0]      m_pix;
    logic [15:0]      in_next;
    logic [15:0]      out_next;
    logic             in_beat;
    logic             in_last;

    assign s_pix    = 16'(s_data);
    assign m_pix    = 16'(m_data);
    assign in_beat  = s_valid & s_ready;
    assign in_last  = (in_cnt == CNT_W'(PIX_N - 1));
    assign in_next  = in_run + s_pix;
    assign out_next = out_run + m_pix;

    // The input side finishes a frame before the output side, so its sum waits in in_pend.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_cnt    <= '0;
            in_run    <= '0;
            in_pend   <= '0;
            out_run   <= '0;
            in_sum    <= '0;
            out_sum   <= '0;
            chk_done  <= 1'b0;
            chk_match <= 1'b0;
        end else begin
            chk_done <= eof_beat;
            if (in_beat) begin
                if (in_last) begin
                    in_cnt  <= '0;
                    in_run  <= '0;
                    in_pend <= in_next;
                end else begin
                    in_cnt <= in_cnt + CNT_W'(1);
                    in_run <= in_next;
                end
            end
            if (out_beat) begin
                if (eof_beat) begin
                    out_run   <= '0;
                    in_sum    <= in_pend;
                    out_sum   <= out_next;
                    chk_match <= (in_pend == out_next);
                end else begin
                    out_run <= out_next;
                end
            end
        end
    end
`else
    assign chk_done  = 1'b0;
    assign chk_match = 1'b0;
    assign in_sum    = 16'd0;
    assign out_sum   = 16'd0;
`endif

endmodule

// File: tb/tb_pixel_stream_pipe.sv
// tb/tb_pixel_stream_pipe.sv - directed self-checking bench for pixel_stream_pipe (4x2 image, depth 2)
module tb_pixel_stream_pipe;
`ifdef PIXPIPE_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_sof;
    logic        m_eol;
    logic        m_eof;
    logic [1:0]  col;
    logic [0:0]  row;
    logic [15:0] frame_cnt;
    logic        chk_done;
    logic        chk_match;
    logic [15:0] in_sum;
    logic [15:0] out_sum;

    int checks = 0;
    int errors = 0;

    pixel_stream_pipe #(.DATA_W(8), .IMG_W(4), .IMG_H(2), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
        .col(col), .row(row), .frame_cnt(frame_cnt),
        .chk_done(chk_done), .chk_match(chk_match),
        .in_sum(in_sum), .out_sum(out_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle(input int n);
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready_low: got %b expected 0", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        checks++; if (chk_done !== 1'b0) begin errors++; $display("FAIL reset_chk_done: got %b expected 0", chk_done); end
        checks++; if (in_sum !== 16'h0 || out_sum !== 16'h0) begin errors++; $display("FAIL reset_sums: got %h/%h expected 0/0", in_sum, out_sum); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL release_s_ready: got %b expected 1", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL release_m_valid: got %b expected 0", m_valid); end
        checks++; if (col !== 2'd0 || row !== 1'd0) begin errors++; $display("FAIL release_pos: got col %0d row %0d expected 0 0", col, row); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL release_frame_cnt: got %0d expected 0", frame_cnt); end
        checks++; if (chk_match !== 1'b0) begin errors++; $display("FAIL release_chk_match: got %b expected 0", chk_match); end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        int sent = 0, rcv = 0, cyc = 0, first_in = -1, first_mv = -1;
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL stream_frame_before: got %0d expected 0", frame_cnt); end
        while (rcv < 8 && cyc < 40) begin
            s_valid = (sent < 8); s_data = 8'(sent); m_ready = 1'b1;
            @(negedge clk);
            if (m_valid && first_mv < 0) first_mv = cyc;
            if (!m_valid) begin
                checks++; if ({m_sof, m_eol, m_eof} !== 3'b000) begin errors++; $display("FAIL stream_markers_idle: got %b expected 000", {m_sof, m_eol, m_eof}); end
            end
            if (m_valid && m_ready) begin
                checks++; if (m_data !== 8'(rcv)) begin errors++; $display("FAIL stream_data: got %h expected %h", m_data, 8'(rcv)); end
                checks++; if (m_sof !== (rcv == 0)) begin errors++; $display("FAIL stream_sof: pixel %0d got %b", rcv, m_sof); end
                checks++; if (m_eol !== (rcv % 4 == 3)) begin errors++; $display("FAIL stream_eol: pixel %0d got %b", rcv, m_eol); end
                checks++; if (m_eof !== (rcv == 7)) begin errors++; $display("FAIL stream_eof: pixel %0d got %b", rcv, m_eof); end
                checks++; if (col !== 2'(rcv % 4) || row !== 1'(rcv / 4)) begin errors++; $display("FAIL stream_pos: pixel %0d got col %0d row %0d", rcv, col, row); end
                rcv++;
            end
            if (s_valid && s_ready) begin
                if (first_in < 0) first_in = cyc;
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        checks++; if (rcv != 8) begin errors++; $display("FAIL stream_count: got %0d pixels expected 8", rcv); end
        checks++; if (first_mv - first_in != 2) begin errors++; $display("FAIL stream_latency: got %0d cycles expected 2", first_mv - first_in); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL stream_frame_after: got %0d expected 1", frame_cnt); end
        idle(2);
    endtask

    task automatic test_backpressure();
        int sent = 0, rcv = 0, cyc = 0, stall_left = 5;
        logic stalling;
        while (rcv < 8 && cyc < 40) begin
            stalling = (rcv == 3) && (stall_left > 0);
            s_valid = (sent < 8); s_data = 8'h20 + 8'(sent); m_ready = !stalling;
            @(negedge clk);
            if (stalling) begin
                checks++; if (m_valid !== 1'b1 || m_data !== 8'h23) begin errors++; $display("FAIL bp_hold: got v=%b d=%h expected v=1 d=23", m_valid, m_data); end
                if (stall_left == 1) begin
                    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready: got %b expected 0", s_ready); end
                end
                stall_left--;
            end else if (rcv >= 3) begin
                checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_gap: pixel %0d got m_valid %b expected 1", rcv, m_valid); end
            end
            if (m_valid && m_ready) begin
                checks++; if (m_data !== 8'h20 + 8'(rcv)) begin errors++; $display("FAIL bp_data: got %h expected %h", m_data, 8'h20 + 8'(rcv)); end
                rcv++;
            end
            if (s_valid && s_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        checks++; if (rcv != 8) begin errors++; $display("FAIL bp_count: got %0d pixels expected 8", rcv); end
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL bp_frame_cnt: got %0d expected 2", frame_cnt); end
        idle(2);
    endtask

    task automatic test_checksum();
        int sent = 0, rcv = 0, cyc = 0, eof_cyc = -1, done_cnt = 0, done_cyc = -1;
        while ((rcv < 8 || cyc <= eof_cyc + 3) && cyc < 40) begin
            s_valid = (sent < 8); s_data = 8'h10 + 8'(sent); m_ready = 1'b1;
            @(negedge clk);
            if (chk_done) begin done_cnt++; done_cyc = cyc; end
            if (m_valid && m_ready) begin
                if (m_eof) eof_cyc = cyc;
                rcv++;
            end
            if (s_valid && s_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        checks++; if (rcv != 8) begin errors++; $display("FAIL chk_count: got %0d pixels expected 8", rcv); end
        checks++; if (done_cnt != (CHK ? 1 : 0)) begin errors++; $display("FAIL chk_done_pulses: got %0d expected %0d", done_cnt, CHK ? 1 : 0); end
        checks++; if (done_cyc != (CHK ? eof_cyc + 1 : -1)) begin errors++; $display("FAIL chk_done_timing: got cycle %0d eof cycle %0d", done_cyc, eof_cyc); end
        checks++; if (in_sum !== (CHK ? 16'h009C : 16'h0000)) begin errors++; $display("FAIL chk_in_sum: got %h expected %h", in_sum, CHK ? 16'h009C : 16'h0000); end
        checks++; if (out_sum !== (CHK ? 16'h009C : 16'h0000)) begin errors++; $display("FAIL chk_out_sum: got %h expected %h", out_sum, CHK ? 16'h009C : 16'h0000); end
        checks++; if (chk_match !== CHK) begin errors++; $display("FAIL chk_match: got %b expected %b", chk_match, CHK); end
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL chk_frame_cnt: got %0d expected 3", frame_cnt); end
        idle(2);
    endtask

    task automatic test_reset_midframe();
        int sent = 0, rcv = 0, cyc = 0;
        while (sent < 3 && cyc < 20) begin
            s_valid = 1'b1; s_data = 8'h30 + 8'(sent); m_ready = 1'b1;
            @(negedge clk);
            if (s_valid && s_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_hs: got v=%b r=%b expected 0 0", m_valid, s_ready); end
        checks++; if (col !== 2'd0 || row !== 1'd0 || frame_cnt !== 16'd0) begin errors++; $display("FAIL mid_reset_cnt: got col %0d row %0d frame %0d", col, row, frame_cnt); end
        @(posedge clk); #1;
        rst = 1'b1;
        sent = 0; cyc = 0;
        while (rcv < 8 && cyc < 40) begin
            s_valid = (sent < 8); s_data = 8'h40 + 8'(sent); m_ready = 1'b1;
            @(negedge clk);
            if (m_valid && m_ready) begin
                if (rcv == 0) begin
                    checks++; if (m_sof !== 1'b1 || col !== 2'd0 || row !== 1'd0) begin errors++; $display("FAIL mid_first: got sof %b col %0d row %0d expected 1 0 0", m_sof, col, row); end
                end
                checks++; if (m_data !== 8'h40 + 8'(rcv)) begin errors++; $display("FAIL mid_data: got %h expected %h", m_data, 8'h40 + 8'(rcv)); end
                rcv++;
            end
            if (s_valid && s_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        checks++; if (rcv != 8) begin errors++; $display("FAIL mid_count: got %0d pixels expected 8", rcv); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL mid_frame_cnt: got %0d expected 1", frame_cnt); end
        checks++; if (in_sum !== (CHK ? 16'h021C : 16'h0000) || chk_match !== CHK) begin errors++; $display("FAIL mid_chk: got sum %h match %b", in_sum, chk_match); end
        idle(2);
    endtask

    initial begin
        rst = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_checksum();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/pixel_stream_pipe.md
# pixel_stream_pipe

Parametrised pixel-stream pass-through: carries a raster image from a source to a sink through a configurable-depth elastic register pipeline with valid/ready flow control. It adds frame-position markers (start of frame, end of line, end of frame) and row/column/frame counters. An optional per-frame checksum confirms the image leaving the block is identical to the image that entered it. It sits between pixel sources (ROM/file readers) and image-processing or dump stages, and replaces the fixed single-register 8-bit pass-through.

## Interface
- DATA_W, 8, pixel width in bits (1..32)
- IMG_W, 256, pixels per line (≥2)
- IMG_H, 256, lines per frame (≥1); IMG_W*IMG_H must exceed DEPTH
- DEPTH, 2, pipeline stages (1..8)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- s_valid  in  1  source pixel valid
- s_ready  out  1  block accepts pixel
- s_data  in  DATA_W  source pixel
- m_valid  out  1  output pixel valid
- m_ready  in  1  sink accepts pixel
- m_data  out  DATA_W  output pixel
- m_sof  out  1  output pixel is (row 0, col 0)
- m_eol  out  1  output pixel is col IMG_W-1
- m_eof  out  1  output pixel is last of frame
- col  out  $clog2(IMG_W)  column of current output pixel
- row  out  $clog2(IMG_H)  row of current output pixel
- frame_cnt  out  16  completed output frames, wraps at 0xFFFF
- chk_done  out  1  one-cycle pulse: frame checksum compared
- chk_match  out  1  result of last comparison, held
- in_sum, out_sum  out  16 each  latched frame sums of last compared frame

## Operation
- Transfer rule: input beat = s_valid & s_ready; output beat = m_valid & m_ready.
- Pipeline: DEPTH stages, each a valid bit and a data register. Stage k loads from stage k-1 when stage k is empty or is itself advancing. Last stage drives m_valid/m_data.
- s_ready = ~stage0_valid | stage0_advancing, so a full pipeline with m_ready=1 sustains one pixel per cycle. No pixel is dropped, duplicated or reordered.
- m_data is held stable while m_valid=1 and m_ready=0.
- Output counters advance on each output beat:
  - col increments; at IMG_W-1 it wraps to 0 and row increments.
  - At row IMG_H-1 with col IMG_W-1, row wraps to 0 and frame_cnt increments.
- Markers are combinational from col/row, ANDed with m_valid (0 when m_valid=0).
- Checksum, when configured:
  - Input side: an input pixel counter plus a 16-bit running sum (zero-extended pixel, modulo 2^16, DATA_W>16 truncated to low 16 bits). On the last input beat of a frame, the final sum is latched as the pending input sum and the running sum restarts at 0.
  - Output side: the same arithmetic over output beats.
  - On the output eof beat: in_sum ← pending input sum, out_sum ← final output sum, chk_match ← equality; chk_done pulses the following cycle.

## Timing
- Reset asserted (rst=0), asynchronously:
  - All stage valids, m_data, col, row, frame_cnt, sums, in_sum, out_sum, chk_done and chk_match are 0.
  - s_ready=0 while reset is asserted; s_ready=1 on the first cycle after release.
- Latency: pixel accepted at edge N appears on m_data after edge N+DEPTH-1, i.e. DEPTH cycles with an empty pipeline and m_ready=1.
- Back-pressure: m_ready low fills the stages; s_ready falls once all DEPTH stages are full and none advance.
- Simultaneous input and output beats on a full pipeline are legal and keep it full.
- chk_done is high for exactly 1 cycle, 1 cycle after the eof output beat.
- Reset mid-frame: all partial frame, counter and sum state is discarded; the next accepted pixel is row 0, col 0.

## Configuration
- PIXPIPE_CHECKSUM_EN defined: checksum logic is built as described.
- Not defined: no checksum logic; chk_done, chk_match, in_sum and out_sum remain as ports, tied to 0. Pipeline, markers and counters are unchanged.

## Test plan
Bench parameters: DATA_W=8, IMG_W=4, IMG_H=2, DEPTH=2, PIXPIPE_CHECKSUM_EN defined.
- Reset: hold rst=0 3 cycles, release -> m_valid=0, s_ready=1, col=row=frame_cnt=0, chk_match=0.
- Stream 0x00..0x07 back-to-back with m_ready=1 -> first m_valid 2 cycles after first accept; m_data 0x00..0x07 consecutive; m_sof on 0x00; m_eol on 0x03 and 0x07; m_eof on 0x07; frame_cnt 0→1.
- Hold m_ready=0 for 5 cycles mid-frame with s_valid=1 -> m_data frozen; s_ready low after 2 stages fill; on release the output sequence continues with no gap or duplicate.
- Frame 0x10..0x17 -> chk_done single pulse; in_sum=out_sum=0x009C; chk_match=1.
- Pulse rst=0 after 3 pixels accepted, then send a full frame -> its first output pixel has m_sof=1, row=col=0; frame_cnt=0 before the frame and 1 after it.
